// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, NOP encoding, the fetch
// FSM state encoding and the pc/instruction buffer entry.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_FETCH = 2'd1,
      FS_FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched pc/instruction pairs until decode
// takes them. Flush dominates a same-cycle push; push on full needs a pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [PW-1:0]               rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        do_push, do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign dout    = mem_q[rd_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      rd_d  = do_pop  ? wrap_inc(rd_q) : rd_q;
      wr_d  = do_push ? wrap_inc(wr_q) : wr_q;
      cnt_d = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order word fetches, buffers responses for
// decode, and squashes in-flight responses after a redirect.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [ILEN-1:0] if_instr,
   output logic            fetch_fault
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic            fire, resp_ok, resp_keep;
   logic            buf_full, buf_empty;
   logic [CW-1:0]   buf_cnt;
   fetch_entry_t    buf_din, buf_head;

   // Outstanding plus buffered bounds the total so every response has a slot.
   assign imem_req  = (state_q == FS_FETCH) && !redirect_valid && !buf_full &&
                      (({1'b0, out_q} + {1'b0, buf_cnt}) < (CW + 1)'(DEPTH));
   assign imem_addr = pc_q;
   assign fire      = imem_req && imem_gnt;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_ok   = imem_rvalid && (out_q != '0);
   assign resp_keep = resp_ok && (drop_q == '0);

   assign buf_din   = '{pc: pc_q - (XLEN'(4) * XLEN'(out_q)), instr: imem_rdata};

   assign if_valid    = !buf_empty && !redirect_valid;
   assign if_pc       = buf_empty ? '0 : buf_head.pc;
   assign if_instr    = buf_empty ? NOP_INSTR : buf_head.instr;
   assign fetch_fault = (state_q == FS_FAULT);

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (resp_keep),
      .pop   (if_valid && if_ready),
      .flush (redirect_valid),
      .din   (buf_din),
      .dout  (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_cnt)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = fire ? pc_q + XLEN'(4) : pc_q;
      out_d   = out_q;
      drop_d  = drop_q;

      if (fire && !resp_ok)
         out_d = out_q + CW'(1);
      else if (!fire && resp_ok)
         out_d = out_q - CW'(1);

      if (resp_ok && (drop_q != '0))
         drop_d = drop_q - CW'(1);

      if (state_q == FS_IDLE)
         state_d = FS_FETCH;

      // No grant is possible here, so out_d already excludes this cycle's response.
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         drop_d  = out_d;
         state_d = (redirect_pc[1:0] != 2'b00) ? FS_FAULT : FS_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FS_IDLE;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed phases push the expected pc/instr
// stream, a negedge monitor checks every pair decode accepts.
module tb_fetch_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   always #5 clk = ~clk;

   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid, fetch_fault;
   logic        if_ready = 1'b1;
   logic [31:0] if_pc, if_instr;

   logic        req2, rv2, fault2, ifv2;
   logic [31:0] addr2, rd2, ifpc2, ifin2;

   logic        hold = 1'b0;
   logic        mem_rv = 1'b0;
   logic [31:0] mem_rd = 32'h0;
   logic [31:0] pend[$];
   logic [31:0] g2[$];
   logic [63:0] exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int n_deliv  = 0;
   int gcnt     = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   fetch_stage dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
      .fetch_fault(fetch_fault)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .reset(reset),
      .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
      .imem_rvalid(rv2), .imem_rdata(rd2),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .if_valid(ifv2), .if_ready(1'b1), .if_pc(ifpc2), .if_instr(ifin2),
      .fetch_fault(fault2)
   );

   assign imem_gnt    = 1'b1;
   assign imem_rvalid = mem_rv;
   assign imem_rdata  = mem_rd;

   // In-order memory, 1-cycle latency; hold stalls responses.
   always @(posedge clk) begin
      if (reset) begin
         pend.delete();
         mem_rv <= 1'b0;
      end else begin
         if (mem_rv) void'(pend.pop_front());
         if (imem_req && imem_gnt) pend.push_back(imem_addr);
         if (!hold && pend.size() > 0) begin
            mem_rv <= 1'b1;
            mem_rd <= instr_of(pend[0]);
         end else begin
            mem_rv <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         rv2 <= 1'b0;
         g2.delete();
      end else begin
         rv2 <= req2;
         rd2 <= instr_of(addr2);
         if (req2) g2.push_back(addr2);
      end
   end

   always @(negedge clk) begin
      if (!reset && imem_req && imem_gnt) gcnt++;
   end

   always @(negedge clk) begin
      logic [63:0] e;
      if (!reset && if_valid && if_ready) begin
         n_checks++;
         n_deliv++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL deliver: got pc %h instr %h, expected nothing", if_pc, if_instr);
         end else begin
            e = exp_q.pop_front();
            if ({if_pc, if_instr} !== e) begin
               n_errors++;
               $display("FAIL deliver: got pc %h instr %h, expected pc %h instr %h",
                        if_pc, if_instr, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({base + 32'(4 * i), instr_of(base + 32'(4 * i))});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_req(input string name, input logic [31:0] addr);
      int k = 0;
      while (!imem_req && k < 10) begin
         tick();
         #3;
         k++;
      end
      chk({name, "_req"}, 32'(imem_req), 32'd1);
      chk(name, imem_addr, addr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0, g0;

      // Reset state and streaming fetch
      do_reset();
      #3;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_instr", if_instr, 32'h0000_0013);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      push_seq(32'h0, 32);
      d0 = n_deliv;
      tick(); #3;
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      repeat (20) tick();
      #3;
      chk("wrap_a0", (g2.size() > 0) ? g2[0] : 32'hx, 32'hFFFF_FFF8);
      chk("wrap_a1", (g2.size() > 1) ? g2[1] : 32'hx, 32'hFFFF_FFFC);
      chk("wrap_a2", (g2.size() > 2) ? g2[2] : 32'hx, 32'h0000_0000);
      chk("stream_deliv", 32'(n_deliv - d0 >= 5), 32'd1);

      // Back-pressure: buffer fills, requests stop
      if_ready = 1'b0;
      do_reset();
      g0 = gcnt;
      repeat (10) tick();
      #3;
      chk("bp_grants", 32'(gcnt - g0), 32'd2);
      chk("bp_req", 32'(imem_req), 32'd0);
      chk("bp_valid", 32'(if_valid), 32'd1);
      chk("bp_head", if_pc, 32'h0);
      push_seq(32'h0, 32);
      tick();
      if_ready = 1'b1;
      #3;
      tick(); #3;
      wait_req("bp_resume", 32'h8);
      repeat (10) tick();

      // Redirect with two requests in flight
      hold = 1'b1;
      do_reset();
      repeat (4) tick();
      #3;
      chk("rd_pre_req", 32'(imem_req), 32'd0);
      chk("rd_pre_valid", 32'(if_valid), 32'd0);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      hold           = 1'b0;
      exp_q.delete();
      push_seq(32'h100, 32);
      #3;
      chk("rd_req", 32'(imem_req), 32'd0);
      chk("rd_valid0", 32'(if_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #3;
      chk("rd_valid1", 32'(if_valid), 32'd0);
      d0 = n_deliv;
      repeat (12) tick();
      #3;
      chk("rd_deliv", 32'(n_deliv - d0 >= 3), 32'd1);

      // Misaligned redirect, then recovery
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      exp_q.delete();
      #3;
      chk("flt_req0", 32'(imem_req), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #3;
      chk("flt_fault", 32'(fetch_fault), 32'd1);
      chk("flt_req1", 32'(imem_req), 32'd0);
      repeat (4) tick();
      #3;
      chk("flt_hold", 32'(fetch_fault), 32'd1);
      chk("flt_req2", 32'(imem_req), 32'd0);
      chk("flt_valid", 32'(if_valid), 32'd0);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      push_seq(32'h200, 32);
      tick();
      redirect_valid = 1'b0;
      #3;
      chk("flt_clear", 32'(fetch_fault), 32'd0);
      wait_req("flt_addr", 32'h200);
      d0 = n_deliv;
      repeat (10) tick();
      #3;
      chk("flt_deliv", 32'(n_deliv - d0 >= 3), 32'd1);

      // Reset with a full buffer
      tick();
      if_ready = 1'b0;
      repeat (8) tick();
      #3;
      chk("mr_pre_valid", 32'(if_valid), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      #3;
      chk("mr_valid", 32'(if_valid), 32'd0);
      chk("mr_req", 32'(imem_req), 32'd0);
      tick();
      reset = 1'b0;
      exp_q.delete();
      push_seq(32'h0, 32);
      if_ready = 1'b1;
      tick(); #3;
      chk("mr_restart_req", 32'(imem_req), 32'd1);
      chk("mr_restart_addr", imem_addr, 32'h0);
      d0 = n_deliv;
      repeat (8) tick();
      #3;
      chk("mr_deliv", 32'(n_deliv - d0 >= 2), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
